// File: rtl/ahb_lite_arbiter.sv
// ahb_lite_arbiter
// Round-robin arbiter that shares one AHB-Lite master port between three
// requesters. Ownership is held across fixed-length bursts (BURST) and
// undefined-length INCR bursts (OPEN), and is only handed over on transfer
// boundaries that the slave has accepted (H_readyN high).
module ahb_lite_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic             H_clk,
  input  logic             H_rstN,
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       H_trans,
  input  logic [2:0]       H_burst,
  input  logic             H_readyN,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic [1:0]       data_sel,
  output logic             locked
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic [2:0] BurstSingle = 3'b000;
  localparam logic [2:0] BurstIncr   = 3'b001;
  localparam logic [2:0] BurstWrap4  = 3'b010;
  localparam logic [2:0] BurstIncr4  = 3'b011;
  localparam logic [2:0] BurstWrap8  = 3'b100;
  localparam logic [2:0] BurstIncr8  = 3'b101;
  localparam logic [2:0] BurstWrap16 = 3'b110;
  localparam logic [2:0] BurstIncr16 = 3'b111;

  localparam logic [N_REQ-1:0] GntPark = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BURST = 2'd1,
    OPEN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [1:0]       r_rrPtr;
  logic [1:0]       r_gntId;
  logic [N_REQ-1:0] r_gnt;
  logic [1:0]       r_dataSel;
  logic             r_locked;

  logic [1:0]       w_cand0;
  logic [1:0]       w_cand1;
  logic [1:0]       w_cand2;
  logic [1:0]       w_winner;
  logic             w_anyReq;

  state_t           w_nState;
  logic [3:0]       w_nCnt;
  logic             w_rearb;

  assign gnt      = r_gnt;
  assign gnt_id   = r_gntId;
  assign data_sel = r_dataSel;
  assign locked   = r_locked;

  // Round-robin search: start one past the last winner and wrap modulo 3
  always_comb begin
    w_cand0  = (r_rrPtr == 2'd2) ? 2'd0 : r_rrPtr + 2'd1;
    w_cand1  = (w_cand0 == 2'd2) ? 2'd0 : w_cand0 + 2'd1;
    w_cand2  = r_rrPtr;
    w_anyReq = |req;
    w_winner = 2'd0;
    if (req[w_cand0]) begin
      w_winner = w_cand0;
    end else if (req[w_cand1]) begin
      w_winner = w_cand1;
    end else if (req[w_cand2]) begin
      w_winner = w_cand2;
    end
  end

  // Next-state decision for an accepted cycle; a NONSEQ seen in OPEN is
  // treated exactly like one seen in ARB so back-to-back bursts reload cleanly
  always_comb begin
    w_nState = r_state;
    w_nCnt   = r_cnt;
    w_rearb  = 1'b0;
    case (r_state)
      ARB, OPEN: begin
        if (H_trans == TransNonseq) begin
          case (H_burst)
            BurstWrap4, BurstIncr4: begin
              w_nState = BURST;
              w_nCnt   = 4'd3;
            end
            BurstWrap8, BurstIncr8: begin
              w_nState = BURST;
              w_nCnt   = 4'd7;
            end
            BurstWrap16, BurstIncr16: begin
              w_nState = BURST;
              w_nCnt   = 4'd15;
            end
            BurstIncr: begin
              w_nState = OPEN;
            end
            BurstSingle: begin
              w_nState = ARB;
              w_rearb  = 1'b1;
            end
            default: begin
              w_nState = ARB;
              w_rearb  = 1'b1;
            end
          endcase
        end else if (H_trans == TransIdle) begin
          if (r_state == ARB) begin
            w_rearb = 1'b1;
          end else if (!req[r_gntId]) begin
            w_nState = ARB;
            w_rearb  = 1'b1;
          end
        end
      end
      BURST: begin
        if (H_trans == TransSeq) begin
          if (r_cnt <= 4'd1) begin
            w_nState = ARB;
            w_nCnt   = 4'd0;
            w_rearb  = 1'b1;
          end else begin
            w_nCnt = r_cnt - 4'd1;
          end
        end
      end
      default: begin
        w_nState = ARB;
        w_nCnt   = 4'd0;
      end
    endcase
  end

  // Arbiter state, grant and data-phase select; everything freezes in wait states
  always_ff @(posedge H_clk or negedge H_rstN) begin
    if (!H_rstN) begin
      r_state   <= ARB;
      r_cnt     <= 4'd0;
      r_rrPtr   <= 2'd0;
      r_gntId   <= 2'd0;
      r_gnt     <= GntPark;
      r_dataSel <= 2'd0;
      r_locked  <= 1'b0;
    end else if (H_readyN) begin
      r_dataSel <= r_gntId;
      r_state   <= w_nState;
      r_cnt     <= w_nCnt;
      r_locked  <= (w_nState != ARB);
      if (w_rearb) begin
        if (w_anyReq) begin
          r_gntId <= w_winner;
          r_gnt   <= GntPark << w_winner;
          r_rrPtr <= w_winner;
        end else begin
          r_gntId <= 2'd0;
          r_gnt   <= GntPark;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// tb_ahb_lite_arbiter
// Directed bench for the round-robin AHB-Lite arbiter; expected grants are
// worked out by hand from the arbitration rules for each scenario.
module tb_ahb_lite_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] WRAP8  = 3'b100;
  localparam logic [2:0] INCR16 = 3'b111;

  logic       H_clk;
  logic       H_rstN;
  logic [2:0] req;
  logic [1:0] H_trans;
  logic [2:0] H_burst;
  logic       H_readyN;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic [1:0] data_sel;
  logic       locked;

  int errCount   = 0;
  int checkCount = 0;

  ahb_lite_arbiter #(.N_REQ(3)) dut (
    .H_clk    (H_clk),
    .H_rstN   (H_rstN),
    .req      (req),
    .H_trans  (H_trans),
    .H_burst  (H_burst),
    .H_readyN (H_readyN),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .data_sel (data_sel),
    .locked   (locked)
  );

  initial H_clk = 1'b0;
  always #5 H_clk = ~H_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the rising edge happen, then settle 1ns
  task automatic applyStimulus(input logic [2:0] r, input logic [1:0] t, input logic [2:0] b, input logic rdy);
    req      = r;
    H_trans  = t;
    H_burst  = b;
    H_readyN = rdy;
    @(posedge H_clk);
    #1;
  endtask

  task automatic checkGrant(input string tag, input logic [2:0] expGnt, input logic [1:0] expId, input logic expLock);
    checkOutput({tag, ".gnt"}, {29'd0, gnt}, {29'd0, expGnt});
    checkOutput({tag, ".gnt_id"}, {30'd0, gnt_id}, {30'd0, expId});
    checkOutput({tag, ".locked"}, {31'd0, locked}, {31'd0, expLock});
  endtask

  logic [2:0] expGntSeq [4];
  logic [1:0] expSelSeq [4];

  initial begin
    expGntSeq[0] = 3'b010; expGntSeq[1] = 3'b100; expGntSeq[2] = 3'b001; expGntSeq[3] = 3'b010;
    expSelSeq[0] = 2'd0;   expSelSeq[1] = 2'd1;   expSelSeq[2] = 2'd2;   expSelSeq[3] = 2'd0;

    H_rstN = 1'b0; req = 3'b000; H_trans = IDLE; H_burst = SINGLE; H_readyN = 1'b1;
    #12;
    checkGrant("reset", 3'b001, 2'd0, 1'b0);
    checkOutput("reset.data_sel", {30'd0, data_sel}, 32'd0);
    #10;
    H_rstN = 1'b1;

    // Free-running round robin with everyone requesting
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b111, IDLE, SINGLE, 1'b1);
      checkOutput($sformatf("rr%0d.gnt", i), {29'd0, gnt}, {29'd0, expGntSeq[i]});
      checkOutput($sformatf("rr%0d.data_sel", i), {30'd0, data_sel}, {30'd0, expSelSeq[i]});
    end

    // Requester 1 runs INCR4; grant moves to 2 on the last SEQ
    applyStimulus(3'b101, NONSEQ, INCR4, 1'b1);
    checkGrant("incr4.nonseq", 3'b010, 2'd1, 1'b1);
    applyStimulus(3'b101, SEQ, INCR4, 1'b1);
    checkGrant("incr4.seq1", 3'b010, 2'd1, 1'b1);
    applyStimulus(3'b101, SEQ, INCR4, 1'b1);
    checkGrant("incr4.seq2", 3'b010, 2'd1, 1'b1);
    applyStimulus(3'b101, SEQ, INCR4, 1'b1);
    checkGrant("incr4.seq3", 3'b100, 2'd2, 1'b0);
    checkOutput("incr4.data_sel", {30'd0, data_sel}, 32'd1);

    // Requester 2 runs WRAP8 with two wait states and one BUSY inserted
    applyStimulus(3'b111, NONSEQ, WRAP8, 1'b1);
    checkGrant("wrap8.nonseq", 3'b100, 2'd2, 1'b1);
    applyStimulus(3'b111, SEQ, WRAP8, 1'b1);
    applyStimulus(3'b111, SEQ, WRAP8, 1'b1);
    applyStimulus(3'b111, SEQ, WRAP8, 1'b0);
    applyStimulus(3'b111, SEQ, WRAP8, 1'b0);
    checkGrant("wrap8.wait", 3'b100, 2'd2, 1'b1);
    checkOutput("wrap8.wait.data_sel", {30'd0, data_sel}, 32'd2);
    applyStimulus(3'b111, BUSY, WRAP8, 1'b1);
    checkGrant("wrap8.busy", 3'b100, 2'd2, 1'b1);
    for (int i = 3; i <= 6; i++) begin
      applyStimulus(3'b111, SEQ, WRAP8, 1'b1);
      checkGrant($sformatf("wrap8.seq%0d", i), 3'b100, 2'd2, 1'b1);
    end
    applyStimulus(3'b111, SEQ, WRAP8, 1'b1);
    checkGrant("wrap8.seq7", 3'b001, 2'd0, 1'b0);

    // Wait state blocks re-arbitration
    applyStimulus(3'b111, IDLE, SINGLE, 1'b0);
    checkGrant("idle.wait", 3'b001, 2'd0, 1'b0);

    // Requester 0 holds an INCR burst open
    applyStimulus(3'b111, NONSEQ, INCR, 1'b1);
    checkGrant("open.nonseq", 3'b001, 2'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'b111, SEQ, INCR, 1'b1);
      checkGrant($sformatf("open.seq%0d", i), 3'b001, 2'd0, 1'b1);
    end
    applyStimulus(3'b111, IDLE, INCR, 1'b1);
    checkGrant("open.idle_req", 3'b001, 2'd0, 1'b1);
    applyStimulus(3'b110, IDLE, INCR, 1'b1);
    checkGrant("open.release", 3'b010, 2'd1, 1'b0);

    // Reset in the middle of an INCR16 owned by requester 1
    applyStimulus(3'b010, NONSEQ, INCR16, 1'b1);
    checkGrant("incr16.nonseq", 3'b010, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(3'b010, SEQ, INCR16, 1'b1);
    #2;
    H_rstN = 1'b0;
    #1;
    checkGrant("midrst", 3'b001, 2'd0, 1'b0);
    checkOutput("midrst.data_sel", {30'd0, data_sel}, 32'd0);
    @(posedge H_clk);
    #2;
    H_rstN = 1'b1;
    applyStimulus(3'b010, SEQ, INCR16, 1'b1);
    checkGrant("postrst.seq", 3'b001, 2'd0, 1'b0);
    applyStimulus(3'b010, IDLE, SINGLE, 1'b1);
    checkGrant("postrst.arb", 3'b010, 2'd1, 1'b0);

    // Parking on requester 0 keeps the round-robin pointer at 2
    applyStimulus(3'b100, IDLE, SINGLE, 1'b1);
    checkGrant("park.own2", 3'b100, 2'd2, 1'b0);
    applyStimulus(3'b000, IDLE, SINGLE, 1'b1);
    checkGrant("park.none", 3'b001, 2'd0, 1'b0);
    applyStimulus(3'b110, NONSEQ, SINGLE, 1'b1);
    checkGrant("park.req110", 3'b010, 2'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ahb_lite_arbiter.md
AHB_LITE_ARBITER -- requirements
Module: ahb_lite_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters sharing one AHB-Lite master port (fixed at 3 for this release).
REQ-002 SHALL have port H_clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port H_rstN  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  3  per-requester bus request; bit i = requester i.
REQ-005 SHALL have port H_trans  input  2  HTRANS of granted requester (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
REQ-006 SHALL have port H_burst  input  3  HBURST of granted requester (SINGLE 000, INCR 001, WRAP4 010, INCR4 011, WRAP8 100, INCR8 101, WRAP16 110, INCR16 111).
REQ-007 SHALL have port H_readyN  input  1  slave ready; 1 = current transfer completes, 0 = wait state.
REQ-008 SHALL have port gnt  output  3  one-hot address-phase grant.
REQ-009 SHALL have port gnt_id  output  2  binary index of gnt; address/control mux select.
REQ-010 SHALL have port data_sel  output  2  data-phase mux select (W_data/R_data routing).
REQ-011 SHALL have port locked  output  1  1 while state is BURST or OPEN.

Function
REQ-012 SHALL implement states ARB, BURST (fixed-length burst in progress), OPEN (INCR undefined-length in progress).
REQ-013 SHALL define "accepted" = H_readyN==1 at the rising edge; no state, grant, counter or pointer change on a non-accepted cycle.
REQ-014 SHALL, in ARB, on accepted NONSEQ with H_burst in {INCR4,WRAP4,INCR8,WRAP8,INCR16,WRAP16}: hold grant, load beat counter with 3/7/15, go BURST.
REQ-015 SHALL, in ARB, on accepted NONSEQ with H_burst==INCR: hold grant, go OPEN.
REQ-016 SHALL, in ARB, on accepted IDLE, or NONSEQ with H_burst==SINGLE: re-arbitrate (REQ-020) at that edge, stay ARB.
REQ-017 SHALL, in BURST, decrement counter on accepted SEQ; BUSY and IDLE do not decrement; on accepted SEQ with counter==1: re-arbitrate, go ARB.
REQ-018 SHALL, in BURST, hold grant while owner req deasserts; burst always completes.
REQ-019 SHALL, in OPEN, on accepted IDLE with owner req==0: re-arbitrate, go ARB; on accepted NONSEQ: reload per REQ-014/015/016 as if in ARB; otherwise hold.
REQ-020 Re-arbitration SHALL be round-robin: search order starts at rr_ptr+1 modulo 3; first requester with req set wins; gnt/gnt_id update at the same edge; rr_ptr <= winner.
REQ-021 SHALL, when re-arbitrating with req==0, park grant on requester 0 without updating rr_ptr.
REQ-022 SHALL update data_sel <= gnt_id on every accepted edge (one-cycle address-to-data pipeline); hold during wait states.
REQ-023 SHALL keep gnt strictly one-hot and gnt_id consistent with gnt in every cycle.
REQ-024 SHALL treat BUSY/SEQ seen in ARB as protocol error: hold grant, no state change.
REQ-025 SHALL keep counter 4 bits, no underflow: decrement only when counter>0.

Reset
REQ-026 SHALL, on H_rstN low, asynchronously set gnt=001, gnt_id=0, data_sel=0, locked=0, state ARB, counter 0, rr_ptr=0.
REQ-027 SHALL, on reset mid-burst, abandon the burst with no residual lock after release.
REQ-028 SHALL resume arbitration on the first rising edge after H_rstN rises.

Verification
REQ-029 Bench: after reset, req=111, H_trans=IDLE, H_readyN=1 each cycle -> gnt sequence 010,100,001,010; data_sel lags gnt_id by one cycle.
REQ-030 Bench: requester 1 owns, NONSEQ INCR4 then 3 SEQ accepted, req=101 -> gnt stays 010 through last SEQ edge, becomes 100 at that edge; locked=1 for 3 cycles.
REQ-031 Bench: WRAP8 burst with H_readyN=0 for 2 cycles mid-burst and one BUSY -> counter, gnt, data_sel frozen during waits/BUSY; exactly 8 beats before handover.
REQ-032 Bench: INCR owner holds OPEN with req=1 for 20 SEQ -> no handover; drop req, drive IDLE -> grant moves to next requester next edge.
REQ-033 Bench: H_rstN pulsed low during INCR16 beat 5 -> gnt=001, locked=0 immediately, no lock after release.
REQ-034 Bench: req=000 after ownership by 2 -> gnt parks 001; then req=110 -> requester 1 wins (rr_ptr still 2, order 0,1 -> 1).
